microcode_decoder: RTL
======================

// Module: microcode_decoder
// PURPOSE
//  Control-side partner of the micro-step counter. Consumes the current step (state[3:0]) and drives the counter's next_state (ENDS=2'b00, NEXT=2'b01) plus a gated step_en.
//  Holds the instruction register, decodes opcode x step into a control word, and stalls on memory handshakes.
//  Detects illegal opcodes, bus timeouts and step overruns. Sits between the step counter, the bus and the datapath.
// PARAMETERS
//  WAIT_MAX  8   max enabled cycles a step may wait for mem_ready before timeout fault
//  CTRL_W    10  control word width (bit map below)
// PORTS
//  clk         in   1       system clock, all state on rising edge
//  rst         in   1       asynchronous, active-high reset
//  clk_en      in   1       global clock enable; no state changes when low
//  state       in   4       current micro-step from step counter
//  data_in     in   8       bus read data
//  mem_ready   in   1       bus read/write completes this cycle
//  next_state  out  2       to counter: 2'b00 ENDS, 2'b01 NEXT; 2'b11 never driven
//  step_en     out  1       counter clk_en = clk_en & ~stall & ~halted
//  ctrl        out  CTRL_W  [0]MEM_RD [1]MEM_WR [2]PC_INC [3]A_LD [4]B_LD [5]ALU_OE [6]PC_LD [7]A_OE [8]HALT [9]IR_LD
//  opcode      out  8       instruction register contents
//  halted      out  1       machine stopped (HLT or fault); sticky until rst
//  fault_code  out  2       00 none, 01 illegal opcode, 10 bus timeout, 11 step overrun; sticky
// BEHAVIOUR
//  Reset (async): IR=8'h00, wait_cnt=0, halted=0, fault_code=00, resync=1.
//  Resync: first enabled cycle after reset drives next_state=ENDS, step_en=1, ctrl=0, then clears resync. Returns the counter to 0 regardless of state.
//  ctrl, next_state, step_en are combinational from state, IR, mem_ready, halted, resync. IR, wait_cnt, faults update only when clk_en=1.
//  Wait steps (marked W) assert stall while mem_ready=0. Access-completion bits (PC_INC, IR_LD, B_LD, PC_LD) assert only in the mem_ready=1 cycle, so each pulses exactly once.
//  wait_cnt increments per stalled enabled cycle and clears on mem_ready or step change.
//  Reaching WAIT_MAX stalled cycles: fault_code=10, halted=1.
//  Step 0 (all opcodes), W: MEM_RD|PC_INC|IR_LD. IR<=data_in on mem_ready. Then NEXT.
//  Opcode class = IR[7:4]:
//   0x0 NOP: s1 ctrl=0, ENDS.
//   0x1 LDA#: s1 W MEM_RD|PC_INC, NEXT. s2 A_LD with data latched in s1 via B path (B_LD in s1), ENDS.
//   0x2 ADD#: s1 W MEM_RD|PC_INC|B_LD, NEXT. s2 ALU_OE|A_LD, ENDS.
//   0x3 STA#: s1 W MEM_WR|A_OE|PC_INC, ENDS.
//   0x4 JMP#: s1 W MEM_RD|PC_LD, ENDS.
//   0xF HLT: s1 HALT; sets halted=1; next_state=ENDS but step_en=0.
//   other: illegal. At s1 fault_code=01, halted=1, ctrl=0.
//  Step overrun: state greater than the opcode's last step, with no fault pending. fault_code=11, halted=1, next_state=ENDS, ctrl=0.
//  While halted: step_en=0, ctrl=0 except HALT=1; IR frozen; only rst exits.
//  First fault wins: a later fault never overwrites a nonzero fault_code.
//  Timeout vs mem_ready in the same cycle: mem_ready wins, no fault.
//  clk_en=0: outputs still decode but step_en=0, no register updates, wait_cnt frozen.
// TESTING
//  rst with state=4'h7 held -> first enabled cycle next_state=00, step_en=1, ctrl=0; then resync clears.
//  Fetch 8'h20 then ADD# with mem_ready after 2 stall cycles each -> PC_INC pulses exactly twice, B_LD once at s1, s2 ALU_OE|A_LD with ENDS.
//  JMP# with mem_ready never asserted, WAIT_MAX=8 -> after 8 stalled enabled cycles fault_code=10, halted=1, step_en=0.
//  Fetch 8'h70 -> at s1 fault_code=01, halted=1; a later forced state=4'h5 leaves fault_code at 01.
//  Fetch 8'h00 then force state=4'h3 -> fault_code=11, next_state=00.
//  Fetch 8'hF0 -> HALT=1, step_en stuck 0 for 20 cycles; clk_en toggling has no effect; rst clears halted.

Source files
------------

// File: rtl/microcode_decoder_if.sv
// Bundles the decoder's step-counter, bus and datapath signals.
interface microcode_decoder_if #(
    parameter int CTRL_W = 10
);
    logic              clk_en;
    logic [3:0]        state;
    logic [7:0]        data_in;
    logic              mem_ready;
    logic [1:0]        next_state;
    logic              step_en;
    logic [CTRL_W-1:0] ctrl;
    logic [7:0]        opcode;
    logic              halted;
    logic [1:0]        fault_code;

    modport master (
        output clk_en, state, data_in, mem_ready,
        input  next_state, step_en, ctrl, opcode, halted, fault_code
    );
    modport slave (
        input  clk_en, state, data_in, mem_ready,
        output next_state, step_en, ctrl, opcode, halted, fault_code
    );
endinterface

// File: rtl/microcode_decoder.sv
// Microcode control unit: decodes IR x micro-step into a control word, steers the step counter,
// stalls on memory handshakes and latches the first fault (illegal opcode, bus timeout, step overrun).
module microcode_decoder #(
    parameter int WAIT_MAX = 8,
    parameter int CTRL_W   = 10
) (
    input  logic               clk,
    input  logic               rst,
    microcode_decoder_if.slave bus
);
    localparam int MEM_RD = 0, MEM_WR = 1, PC_INC = 2, A_LD = 3, B_LD = 4;
    localparam int ALU_OE = 5, PC_LD = 6, A_OE = 7, HALT = 8, IR_LD = 9;
    localparam logic [1:0] ENDS = 2'b00, NEXT = 2'b01;
    localparam int WCW = $clog2(WAIT_MAX + 1);

    logic [7:0]        ir;
    logic [WCW-1:0]    wait_cnt;
    logic [WCW-1:0]    wait_inc;
    logic [3:0]        last_state;
    logic              resync;
    logic              halted;
    logic [1:0]        fault_code;

    logic [CTRL_W-1:0] ctrl_c;
    logic [1:0]        next_c;
    logic              stall;
    logic              stop;
    logic [1:0]        fault_c;
    logic [3:0]        last_step;
    logic [3:0]        cls;

    assign cls = ir[7:4];

    always_comb begin
        ctrl_c    = '0;
        next_c    = ENDS;
        stall     = 1'b0;
        stop      = 1'b0;
        fault_c   = 2'b00;
        last_step = (cls == 4'h1 || cls == 4'h2) ? 4'd2 : 4'd1;
        if (resync) begin
            next_c = ENDS;
        end else if (halted) begin
            ctrl_c[HALT] = 1'b1;
        end else if (bus.state > last_step) begin
            stop    = 1'b1;
            fault_c = 2'b11;
        end else if (bus.state == 4'd0) begin
            // Fetch: completion bits only in the ready cycle so each pulses once.
            stall          = ~bus.mem_ready;
            next_c         = NEXT;
            ctrl_c[MEM_RD] = 1'b1;
            ctrl_c[PC_INC] = bus.mem_ready;
            ctrl_c[IR_LD]  = bus.mem_ready;
        end else if (bus.state == 4'd1) begin
            case (cls)
                4'h0: ;
                4'h1, 4'h2: begin
                    stall          = ~bus.mem_ready;
                    next_c         = NEXT;
                    ctrl_c[MEM_RD] = 1'b1;
                    ctrl_c[PC_INC] = bus.mem_ready;
                    ctrl_c[B_LD]   = bus.mem_ready;
                end
                4'h3: begin
                    stall          = ~bus.mem_ready;
                    ctrl_c[MEM_WR] = 1'b1;
                    ctrl_c[A_OE]   = 1'b1;
                    ctrl_c[PC_INC] = bus.mem_ready;
                end
                4'h4: begin
                    stall          = ~bus.mem_ready;
                    ctrl_c[MEM_RD] = 1'b1;
                    ctrl_c[PC_LD]  = bus.mem_ready;
                end
                4'hF: begin
                    stop         = 1'b1;
                    ctrl_c[HALT] = 1'b1;
                end
                default: begin
                    stop    = 1'b1;
                    fault_c = 2'b01;
                end
            endcase
        end else begin
            ctrl_c[A_LD]   = 1'b1;
            ctrl_c[ALU_OE] = (cls == 4'h2);
        end
    end

    // Stall count restarts whenever the counter has moved to a different step.
    assign wait_inc = ((bus.state == last_state) ? wait_cnt : '0) + WCW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir         <= 8'h00;
            wait_cnt   <= '0;
            last_state <= 4'd0;
            resync     <= 1'b1;
            halted     <= 1'b0;
            fault_code <= 2'b00;
        end else if (bus.clk_en) begin
            if (resync) begin
                resync     <= 1'b0;
                wait_cnt   <= '0;
                last_state <= bus.state;
            end else if (!halted) begin
                last_state <= bus.state;
                if (ctrl_c[IR_LD])
                    ir <= bus.data_in;
                if (stall) begin
                    wait_cnt <= wait_inc;
                    if (wait_inc == WCW'(WAIT_MAX)) begin
                        fault_code <= 2'b10;
                        halted     <= 1'b1;
                    end
                end else begin
                    wait_cnt <= '0;
                end
                if (stop) begin
                    fault_code <= fault_c;
                    halted     <= 1'b1;
                end
            end
        end
    end

    assign bus.ctrl       = ctrl_c;
    assign bus.next_state = next_c;
    assign bus.step_en    = bus.clk_en & (resync | (~stall & ~halted & ~stop));
    assign bus.opcode     = ir;
    assign bus.halted     = halted;
    assign bus.fault_code = fault_code;
endmodule
